rom_to_ram_copier: RTL and testbench

- Parametrised successor of the ROM-to-RAM loader: a one-shot DMA-style copy engine.
- Copies LEN words from a ROM source window to a RAM destination window, or fills a RAM window with a constant.
- Drives the ROM read port and the RAM write port directly; the integrator owns both memories.
- Handshake is start/busy/done/abort. ROM read latency is parametrised so the same engine serves combinational and registered ROMs.

---
 rtl/rom_to_ram_copier.sv | 168 ++++++++++++++++
 tb/tb_rom_to_ram_copier.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_to_ram_copier.sv
// One-shot copy engine: streams LEN words from a ROM window into a RAM window,
// or fills a RAM window with a constant, with a parametrised ROM read latency.
module rom_to_ram_copier #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int PIPE_W = (ROM_LATENCY > 0) ? ROM_LATENCY : 1;
    localparam int CNT_W  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [CNT_W-1:0]      words_q, words_d;
    logic                  aborted_q, aborted_d;
    logic [PIPE_W-1:0]     vld_q, vld_d;

    logic active;
    logic abort_act;
    logic issue;
    logic last_issue;
    logic tok_out;

    always_comb begin
        active     = (state_q == S_RUN) || (state_q == S_DRAIN);
        abort_act  = active && abort;
        issue      = (state_q == S_RUN) && !abort;
        last_issue = ((issued_q + CNT_W'(1)) == len_q);
        // With zero latency the issue cycle is also the write cycle.
        if (ROM_LATENCY == 0) begin
            tok_out = issue;
        end else begin
            tok_out = vld_q[PIPE_W-1] && !abort_act;
        end
    end

    // Valid-token delay line matching the ROM read latency; abort flushes it.
    always_comb begin
        vld_d = '0;
        if (ROM_LATENCY > 0 && !abort_act) begin
            vld_d[0] = issue;
            for (int i = 1; i < PIPE_W; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        fill_d    = fill_q;
        issued_d  = issued_q;
        words_d   = words_q;
        aborted_d = aborted_q;

        if (tok_out) begin
            words_d = words_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    mode_d    = mode;
                    src_d     = src_base;
                    dst_d     = dst_base;
                    len_d     = len;
                    fill_d    = fill_data;
                    issued_d  = '0;
                    words_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    issued_d = issued_q + CNT_W'(1);
                    if (last_issue) begin
                        state_d = (ROM_LATENCY == 0) ? S_DONE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once the token at the output is the last one in flight.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (vld_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            vld_q     <= '0;
            issued_q  <= '0;
            words_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_q     <= vld_d;
            issued_q  <= issued_d;
            words_q   <= words_d;
            aborted_q <= aborted_d;
        end
    end

    // Captured transfer parameters only matter once a start has loaded them.
    always_ff @(posedge clk) begin
        mode_q <= mode_d;
        src_q  <= src_d;
        dst_q  <= dst_d;
        len_q  <= len_d;
        fill_q <= fill_d;
    end

    always_comb begin
        rom_addr      = (state_q == S_RUN) ? (src_q + issued_q[ADDR_WIDTH-1:0]) : '0;
        ram_we        = tok_out;
        ram_addr      = tok_out ? (dst_q + words_q[ADDR_WIDTH-1:0]) : '0;
        ram_wdata     = tok_out ? (mode_q ? fill_q : rom_data) : '0;
        busy          = active;
        done          = (state_q == S_DONE);
        aborted       = aborted_q;
        words_written = words_q;
    end

endmodule

// File: tb/tb_rom_to_ram_copier.sv
// Bench for rom_to_ram_copier: three engines (ROM latency 1, 3, 0) with ROM/RAM
// models, a directed vector table, hand-written corner sequences and random transfers.
module tb_rom_to_ram_copier;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_s     [NI];
    logic          start_s   [NI];
    logic          abort_s   [NI];
    logic          mode_s    [NI];
    logic [AW-1:0] src_s     [NI];
    logic [AW-1:0] dst_s     [NI];
    logic [AW:0]   len_s     [NI];
    logic [DW-1:0] fill_s    [NI];
    logic [AW-1:0] rom_addr_s[NI];
    logic [DW-1:0] rom_data_s[NI];
    logic          ram_we_s  [NI];
    logic [AW-1:0] ram_addr_s[NI];
    logic [DW-1:0] ram_wdata_s[NI];
    logic          busy_s    [NI];
    logic          done_s    [NI];
    logic          aborted_s [NI];
    logic [AW:0]   words_s   [NI];

    logic [DW-1:0] rom_mem [4096];
    logic [DW-1:0] ram_m   [NI][4096];
    logic [DW-1:0] exp_ram [NI][4096];
    logic [AW-1:0] apipe   [NI][4];
    int            we_cnt  [NI];
    logic          ram_clr;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_eng
        localparam int LAT  = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        localparam int LATI = (LAT == 0) ? 0 : LAT - 1;
        assign rom_data_s[g] = (LAT == 0) ? rom_mem[rom_addr_s[g]] : rom_mem[apipe[g][LATI]];
        rom_to_ram_copier #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT)) u_dut (
            .clk(clk), .reset(rst_s[g]), .start(start_s[g]), .abort(abort_s[g]),
            .mode(mode_s[g]), .src_base(src_s[g]), .dst_base(dst_s[g]), .len(len_s[g]),
            .fill_data(fill_s[g]), .rom_addr(rom_addr_s[g]), .rom_data(rom_data_s[g]),
            .ram_we(ram_we_s[g]), .ram_addr(ram_addr_s[g]), .ram_wdata(ram_wdata_s[g]),
            .busy(busy_s[g]), .done(done_s[g]), .aborted(aborted_s[g]),
            .words_written(words_s[g])
        );
    end

    // Registered ROM address pipe and RAM write port shared by all engines.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            apipe[k][0] <= rom_addr_s[k];
            for (int j = 1; j < 4; j++) apipe[k][j] <= apipe[k][j-1];
            if (ram_clr) begin
                for (int a = 0; a < 4096; a++) ram_m[k][a] <= '0;
            end else if (ram_we_s[k]) begin
                ram_m[k][ram_addr_s[k]] <= ram_wdata_s[k];
                we_cnt[k] <= we_cnt[k] + 1;
            end
        end
    end

    task automatic check(input string nm, input longint got, input longint req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic check_ram(input int k, input string nm);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int a = 0; a < 4096; a++) begin
            if (ram_m[k][a] !== exp_ram[k][a]) begin
                if (first < 0) first = a;
                bad++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d words differ, ram[%03h] got %02h required %02h",
                     nm, bad, first, ram_m[k][first], exp_ram[k][first]);
        end
    endtask

    // Reference: the first nw words of the window land at dst+i (mod depth).
    task automatic model_write(input int k, input logic md, input logic [AW-1:0] src,
                               input logic [AW-1:0] dst, input logic [DW-1:0] fd, input int nw);
        for (int i = 0; i < nw; i++) begin
            exp_ram[k][AW'(dst + AW'(i))] = md ? fd : rom_mem[AW'(src + AW'(i))];
        end
    endtask

    // Reference outcome: writes land RUN-index i+L; abort at RUN/DRAIN index a kills writes from a on.
    function automatic void expect_of(input int lat, input int ln, input int a,
                                      output int nw, output int cyc, output int ab);
        if (ln == 0) begin
            nw = 0; cyc = 2; ab = 0;
        end else if (a >= 0 && a < ln + lat) begin
            nw = (a - lat < 0) ? 0 : ((a - lat > ln) ? ln : a - lat);
            cyc = a + 3; ab = 1;
        end else begin
            nw = ln; cyc = ln + lat + 2; ab = 0;
        end
    endfunction

    // cyc counts cycles inclusively from the start cycle through the done cycle.
    task automatic run_xfer(input int k, input logic md, input logic [AW-1:0] src,
                            input logic [AW-1:0] dst, input logic [AW:0] ln,
                            input logic [DW-1:0] fd, input int ab_at,
                            output int cyc, output int ww, output int ab, output int nwr);
        int base;
        base = we_cnt[k];
        cyc = -1; ww = -1; ab = -1;
        @(negedge clk);
        start_s[k] = 1'b1; mode_s[k] = md; src_s[k] = src; dst_s[k] = dst;
        len_s[k] = ln; fill_s[k] = fd;
        @(negedge clk);
        start_s[k] = 1'b0; mode_s[k] = ~md; src_s[k] = AW'($urandom);
        dst_s[k] = AW'($urandom); len_s[k] = (AW+1)'($urandom); fill_s[k] = DW'($urandom);
        check("busy_first_cycle", busy_s[k], (ln != 0));
        for (int n = 1; n <= int'(ln) + 12; n++) begin
            if (done_s[k]) begin
                cyc = n + 1; ww = int'(words_s[k]); ab = int'(aborted_s[k]);
                check("busy_at_done", busy_s[k], 0);
                break;
            end
            abort_s[k] = (n == ab_at + 1);
            @(negedge clk);
        end
        abort_s[k] = 1'b0;
        if (cyc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: engine %0d got no done, required one", k);
        end
        @(negedge clk);
        check("done_one_cycle", done_s[k], 0);
        nwr = we_cnt[k] - base;
    endtask

    typedef struct {
        int            k;
        logic          md;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   ln;
        logic [DW-1:0] fd;
        int            ab_at;
        int            exp_ww;
        int            exp_ab;
        int            exp_cyc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ww, ab, nwr, e_nw, e_cyc, e_ab, dn, wecnt, base;

        for (int i = 0; i < 4096; i++) rom_mem[i] = DW'(i + 'h40) ^ DW'((i >> 8) * 'h1D);
        for (int k = 0; k < NI; k++) begin
            rst_s[k] = 1'b0; start_s[k] = 1'b0; abort_s[k] = 1'b0; mode_s[k] = 1'b0;
            src_s[k] = '0; dst_s[k] = '0; len_s[k] = '0; fill_s[k] = '0;
            for (int a = 0; a < 4096; a++) exp_ram[k][a] = '0;
        end
        ram_clr = 1'b1;
        repeat (3) @(negedge clk);
        ram_clr = 1'b0;
        for (int k = 0; k < NI; k++) rst_s[k] = 1'b1;

        for (int k = 0; k < NI; k++) begin
            check("rst_busy", busy_s[k], 0);
            check("rst_done", done_s[k], 0);
            check("rst_ram_we", ram_we_s[k], 0);
            check("rst_rom_addr", rom_addr_s[k], 0);
            check("rst_words", words_s[k], 0);
            check("rst_aborted", aborted_s[k], 0);
        end

        vecs[0] = '{0, 1'b0, 12'h010, 12'h200, 13'd4,    8'h00, -1, 4,    0, 7};
        vecs[1] = '{0, 1'b1, 12'h123, 12'hFFE, 13'd4,    8'hA5, -1, 4,    0, 7};
        vecs[2] = '{0, 1'b0, 12'h050, 12'h300, 13'd0,    8'h11, -1, 0,    0, 2};
        vecs[3] = '{1, 1'b0, 12'h300, 12'h400, 13'd10,   8'h00, 5,  2,    1, 8};
        vecs[4] = '{2, 1'b0, 12'h000, 12'h000, 13'h1000, 8'h00, -1, 4096, 0, 4098};
        vecs[5] = '{1, 1'b0, 12'hFFF, 12'h010, 13'd3,    8'h00, -1, 3,    0, 8};
        vecs[6] = '{2, 1'b1, 12'h080, 12'h0F0, 13'd5,    8'h3C, 2,  2,    1, 5};
        vecs[7] = '{0, 1'b0, 12'h020, 12'h900, 13'd3,    8'h00, 3,  2,    1, 6};

        for (int v = 0; v < 8; v++) begin
            run_xfer(vecs[v].k, vecs[v].md, vecs[v].src, vecs[v].dst, vecs[v].ln,
                     vecs[v].fd, vecs[v].ab_at, cyc, ww, ab, nwr);
            check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cyc);
            check($sformatf("vec%0d_words_written", v), ww, vecs[v].exp_ww);
            check($sformatf("vec%0d_aborted", v), ab, vecs[v].exp_ab);
            check($sformatf("vec%0d_ram_we_count", v), nwr, vecs[v].exp_ww);
            model_write(vecs[v].k, vecs[v].md, vecs[v].src, vecs[v].dst, vecs[v].fd, vecs[v].exp_ww);
            check_ram(vecs[v].k, $sformatf("vec%0d_ram", v));
        end

        // start together with abort in IDLE must not launch a transfer.
        @(negedge clk);
        start_s[1] = 1'b1; abort_s[1] = 1'b1; len_s[1] = 13'd5;
        @(negedge clk);
        start_s[1] = 1'b0; abort_s[1] = 1'b0;
        dn = 0; wecnt = 0;
        for (int n = 0; n < 10; n++) begin
            dn += int'(done_s[1]) + int'(busy_s[1]);
            @(negedge clk);
        end
        check("start_with_abort_ignored", dn, 0);

        // Re-pulsed start while busy is ignored; reset mid-transfer kills it.
        base = we_cnt[0];
        @(negedge clk);
        start_s[0] = 1'b1; mode_s[0] = 1'b0; src_s[0] = 12'h500; dst_s[0] = 12'h600;
        len_s[0] = 13'd20; fill_s[0] = 8'h00;
        @(negedge clk);
        start_s[0] = 1'b0;
        dn = 0;
        for (int n = 1; n <= 8; n++) begin
            dn += int'(done_s[0]);
            start_s[0] = (n == 3);
            if (n == 3) begin
                len_s[0] = 13'd1; dst_s[0] = 12'h700; src_s[0] = 12'h000; mode_s[0] = 1'b1;
            end
            if (n == 7) check("busy_before_reset", busy_s[0], 1);
            rst_s[0] = (n == 8) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        start_s[0] = 1'b0;
        rst_s[0] = 1'b1;
        check("midrst_busy", busy_s[0], 0);
        check("midrst_done", done_s[0], 0);
        check("midrst_ram_we", ram_we_s[0], 0);
        check("midrst_rom_addr", rom_addr_s[0], 0);
        check("midrst_ram_addr", ram_addr_s[0], 0);
        check("midrst_ram_wdata", ram_wdata_s[0], 0);
        check("midrst_words", words_s[0], 0);
        check("midrst_aborted", aborted_s[0], 0);
        for (int n = 0; n < 30; n++) begin
            dn += int'(done_s[0]);
            @(negedge clk);
        end
        check("midrst_no_done", dn, 0);
        // Writes in RUN cycles 2..8 land before the reset edge takes effect.
        check("midrst_write_count", we_cnt[0] - base, 7);
        model_write(0, 1'b0, 12'h500, 12'h600, 8'h00, 7);
        check_ram(0, "midrst_ram");

        for (int t = 0; t < 40; t++) begin
            int k, ln, a;
            logic md;
            logic [AW-1:0] src, dst;
            logic [DW-1:0] fd;
            k   = $urandom_range(0, NI - 1);
            md  = 1'($urandom);
            src = AW'($urandom);
            dst = AW'($urandom);
            fd  = DW'($urandom);
            ln  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            a   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ln + 4) : -1;
            expect_of(lat_of(k), ln, a, e_nw, e_cyc, e_ab);
            run_xfer(k, md, src, dst, (AW+1)'(ln), fd, a, cyc, ww, ab, nwr);
            check($sformatf("rnd%0d_cycles", t), cyc, e_cyc);
            check($sformatf("rnd%0d_words_written", t), ww, e_nw);
            check($sformatf("rnd%0d_aborted", t), ab, e_ab);
            check($sformatf("rnd%0d_ram_we_count", t), nwr, e_nw);
            model_write(k, md, src, dst, fd, e_nw);
            check_ram(k, $sformatf("rnd%0d_ram", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
